// File: rtl/multiplexer_rr_stream.sv
// N-channel stream multiplexer with a registered output word, valid/ready on every port,
// and either fixed (s) or round-robin channel selection.
module multiplexer_rr_stream #(
    parameter  int N_CH  = 4,
    parameter  int W     = 1,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic [SEL_W-1:0]    s,
    input  logic [N_CH*W-1:0]   in_data,
    input  logic [N_CH-1:0]     in_valid,
    output logic [N_CH-1:0]     in_ready,
    output logic [W-1:0]        out_data,
    output logic [SEL_W-1:0]    out_ch,
    output logic                out_valid,
    input  logic                out_ready
);

    logic [SEL_W-1:0] ptr;
    logic             free;
    logic             found;
    logic             grant;
    logic [SEL_W-1:0] gidx;
    logic [SEL_W-1:0] ptr_next;
    logic [W-1:0]     sel_data;

    assign free  = !out_valid || out_ready;
    assign grant = found && free && !reset;

    // Round-robin scan runs from the farthest candidate back to ptr so the
    // nearest valid channel after ptr is the one left in gidx.
    always_comb begin
        int               j;
        logic [SEL_W-1:0] jj;
        found = 1'b0;
        gidx  = '0;
        j     = 0;
        jj    = '0;
        if (!mode) begin
            for (int k = 0; k < N_CH; k++) begin
                if (s == SEL_W'(k) && in_valid[k]) begin
                    found = 1'b1;
                    gidx  = SEL_W'(k);
                end
            end
        end else begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                j = int'(ptr) + i;
                if (j >= N_CH) begin
                    j = j - N_CH;
                end
                jj = SEL_W'(j);
                if (in_valid[jj]) begin
                    found = 1'b1;
                    gidx  = jj;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        sel_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (gidx == SEL_W'(k)) begin
                in_ready[k] = grant;
                sel_data    = in_data[k*W +: W];
            end
        end
    end

    assign ptr_next = (gidx == SEL_W'(N_CH - 1)) ? '0 : gidx + SEL_W'(1);

    // A free slot either takes the granted word or empties; a stalled slot holds everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (free) begin
            if (grant) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_ch    <= gidx;
                if (mode) begin
                    ptr <= ptr_next;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multiplexer_rr_stream.sv
// Bench for multiplexer_rr_stream: directed vectors feed an expected-word queue that a
// negedge monitor drains whenever the output handshake completes.
module tb_multiplexer_rr_stream;

    logic        clock;
    logic        reset;
    logic        mode;
    logic [1:0]  s;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic [1:0]  s3;
    logic [11:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [3:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;

    typedef struct {
        logic [3:0] data;
        logic [1:0] ch;
    } word_t;

    word_t expq[$];
    int    total = 0;
    int    bad   = 0;

    multiplexer_rr_stream #(.N_CH(4), .W(4)) dut (
        .clock(clock), .reset(reset), .mode(mode), .s(s),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    multiplexer_rr_stream #(.N_CH(3), .W(4)) dut3 (
        .clock(clock), .reset(reset), .mode(1'b0), .s(s3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
        .out_ready(1'b1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic m, input logic [1:0] sel, input logic [3:0] v, input logic rdy);
        mode      = m;
        s         = sel;
        in_valid  = v;
        out_ready = rdy;
        #1;
    endtask

    task automatic pushExp(input logic [3:0] d, input logic [1:0] c);
        word_t w;
        w.data = d;
        w.ch   = c;
        expq.push_back(w);
    endtask

    // Every completed output handshake must match the oldest expected word.
    initial begin
        word_t w;
        forever begin
            @(negedge clock);
            if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_word: got ch=%0d data=%0h expected none", out_ch, out_data);
                end else begin
                    w = expq.pop_front();
                    checkOutput("mon_data", 32'(out_data), 32'(w.data));
                    checkOutput("mon_ch", 32'(out_ch), 32'(w.ch));
                end
            end
        end
    end

    initial begin
        logic [3:0] rr_data [4];
        rr_data[0] = 4'hA;
        rr_data[1] = 4'hB;
        rr_data[2] = 4'hC;
        rr_data[3] = 4'hD;

        reset     = 1'b1;
        mode      = 1'b0;
        s         = 2'd0;
        in_data   = 16'hDCBA;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        s3        = 2'd0;
        in_data3  = 12'h987;
        in_valid3 = 3'b000;
        tick();
        tick();
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(out_data), 32'd0);
        checkOutput("reset_out_ch", 32'(out_ch), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;

        // Fixed select walking s across all channels
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 2'(k), 4'hF, 1'b1);
            checkOutput("fixed_in_ready", 32'(in_ready), 32'(4'b0001 << k));
            pushExp(rr_data[k], 2'(k));
            tick();
            checkOutput("fixed_out_valid", 32'(out_valid), 32'd1);
        end
        applyStimulus(1'b0, 2'd0, 4'h0, 1'b1);
        tick();
        checkOutput("fixed_drain", 32'(out_valid), 32'd0);

        // Round-robin with every channel valid, starting from a fresh pointer
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 2'd0, 4'hF, 1'b1);
        checkOutput("rr_first_ready", 32'(in_ready), 32'b0001);
        for (int i = 0; i < 6; i++) begin
            pushExp(rr_data[i % 4], 2'(i % 4));
            tick();
            checkOutput("rr_continuous_valid", 32'(out_valid), 32'd1);
        end
        applyStimulus(1'b1, 2'd0, 4'h0, 1'b1);
        tick();
        checkOutput("rr_drain", 32'(out_valid), 32'd0);

        // Round-robin over the sparse pattern 1010
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 2'd0, 4'b1010, 1'b1);
        pushExp(4'hB, 2'd1);
        pushExp(4'hD, 2'd3);
        pushExp(4'hB, 2'd1);
        pushExp(4'hD, 2'd3);
        repeat (4) tick();
        applyStimulus(1'b1, 2'd0, 4'h0, 1'b1);
        tick();
        checkOutput("sparse_drain", 32'(out_valid), 32'd0);

        // Stall with a channel-2 word, inputs scrambled underneath it
        applyStimulus(1'b0, 2'd2, 4'hF, 1'b1);
        pushExp(4'hC, 2'd2);
        tick();
        applyStimulus(1'b0, 2'd3, 4'hF, 1'b0);
        in_data = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_out_data", 32'(out_data), 32'hC);
            checkOutput("stall_out_ch", 32'(out_ch), 32'd2);
            checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
            tick();
        end
        in_data = 16'hDCBA;
        applyStimulus(1'b0, 2'd3, 4'hF, 1'b1);
        checkOutput("unstall_in_ready", 32'(in_ready), 32'b1000);
        pushExp(4'hD, 2'd3);
        tick();
        checkOutput("unstall_out_ch", 32'(out_ch), 32'd3);
        applyStimulus(1'b0, 2'd3, 4'h0, 1'b1);
        tick();

        // Fixed select pointing at an idle channel, and an out-of-range select on N_CH=3
        applyStimulus(1'b0, 2'd2, 4'b1011, 1'b1);
        checkOutput("idle_sel_in_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("idle_sel_out_valid", 32'(out_valid), 32'd0);
        s3        = 2'd3;
        in_valid3 = 3'b111;
        #1;
        checkOutput("n3_oob_in_ready", 32'(in_ready3), 32'd0);
        tick();
        checkOutput("n3_oob_out_valid", 32'(out_valid3), 32'd0);
        s3 = 2'd2;
        #1;
        checkOutput("n3_sel2_in_ready", 32'(in_ready3), 32'b100);
        tick();
        checkOutput("n3_sel2_out_valid", 32'(out_valid3), 32'd1);
        checkOutput("n3_sel2_out_data", 32'(out_data3), 32'h9);
        checkOutput("n3_sel2_out_ch", 32'(out_ch3), 32'd2);

        // Reset while a word is held under backpressure
        applyStimulus(1'b1, 2'd0, 4'b0100, 1'b1);
        pushExp(4'hC, 2'd2);
        tick();
        applyStimulus(1'b1, 2'd0, 4'hF, 1'b0);
        checkOutput("pre_reset_out_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        expq.delete();
        #1;
        checkOutput("in_reset_in_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("post_reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("post_reset_out_data", 32'(out_data), 32'd0);
        checkOutput("post_reset_out_ch", 32'(out_ch), 32'd0);
        reset = 1'b0;
        applyStimulus(1'b1, 2'd0, 4'hF, 1'b1);
        checkOutput("restart_in_ready", 32'(in_ready), 32'b0001);
        pushExp(4'hA, 2'd0);
        tick();
        applyStimulus(1'b1, 2'd0, 4'h0, 1'b1);
        tick();
        checkOutput("restart_drain", 32'(out_valid), 32'd0);

        tick();
        checkOutput("queue_empty", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
